// File: rtl/mac_pkg.sv
// Shared definitions for the SIMD multiply-accumulate processing element:
// default widths, the dot-product width rule and the overflow/saturation helper.
package mac_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 32;
   localparam int LANES_DEF  = 4;

   // Widest exact sum the overflow helper handles. Accumulators must leave
   // two spare bits so an unsigned accumulator plus a signed dot sum never aliases.
   localparam int MAX_W = 128;

   // Width that holds a LANES-wide dot sum exactly in either signedness.
   function automatic int dotWidth(input int dataW, input int lanes);
      return 2 * dataW + $clog2(lanes) + 1;
   endfunction

   // Checks an exact sum against the accumulator range of the sample's mode.
   // Returns the clamped bound when saturating, otherwise the sum itself,
   // whose low accW bits are the wrapped result.
   function automatic logic [MAX_W-1:0] accSatOvf(
      input  logic signed [MAX_W-1:0] sum,
      input  int                      accW,
      input  logic                    isSigned,
      input  logic                    satEn,
      output logic                    ovf
   );
      logic signed [MAX_W-1:0] one;
      logic signed [MAX_W-1:0] hiBound;
      logic signed [MAX_W-1:0] loBound;
      logic [MAX_W-1:0]        res;
      one = {{(MAX_W-1){1'b0}}, 1'b1};
      if (isSigned) begin
         hiBound = (one <<< (accW - 1)) - one;
         loBound = -(one <<< (accW - 1));
      end else begin
         hiBound = (one <<< accW) - one;
         loBound = '0;
      end
      ovf = (sum > hiBound) || (sum < loBound);
      if (ovf && satEn) begin
         res = (sum > hiBound) ? hiBound : loBound;
      end else begin
         res = sum;
      end
      return res;
   endfunction

endpackage

// File: rtl/mac_pe_simd_if.sv
// Bundle of the data, weight and status signals of one mac_pe_simd,
// seen from the driver (master) and from the processing element (slave).
interface mac_pe_simd_if import mac_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int LANES  = LANES_DEF
);

   logic                      mode_signed;
   logic                      sat_en;
   logic                      wt_load;
   logic [LANES*DATA_W-1:0]   wt_path_in;
   logic [LANES*DATA_W-1:0]   wt_path_out;
   logic                      valid_in;
   logic [LANES*DATA_W-1:0]   data_in;
   logic [ACC_W-1:0]          acc_in;
   logic [LANES*DATA_W-1:0]   data_out;
   logic                      data_valid_out;
   logic [ACC_W-1:0]          acc_out;
   logic                      acc_valid_out;
   logic                      ovf_clr;
   logic                      ovf_sticky;

   modport master (
      output mode_signed, sat_en, wt_load, wt_path_in, valid_in, data_in, acc_in, ovf_clr,
      input  wt_path_out, data_out, data_valid_out, acc_out, acc_valid_out, ovf_sticky
   );

   modport slave (
      input  mode_signed, sat_en, wt_load, wt_path_in, valid_in, data_in, acc_in, ovf_clr,
      output wt_path_out, data_out, data_valid_out, acc_out, acc_valid_out, ovf_sticky
   );

endinterface

// File: rtl/mac_dot_lanes.sv
// Combinational LANES-wide dot product of activations and weights,
// treating operands as two's complement or unsigned on request.
module mac_dot_lanes import mac_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LANES  = LANES_DEF,
   parameter int DOT_W  = dotWidth(DATA_W, LANES)
) (
   input  logic [LANES*DATA_W-1:0] data_i,
   input  logic [LANES*DATA_W-1:0] wt_i,
   input  logic                    modeSigned_i,
   output logic signed [DOT_W-1:0] dot_o
);

   // Extend every lane to the full dot width first; each product and the
   // running sum then fit exactly, so the low DOT_W bits are the true result.
   always_comb begin
      logic [DATA_W-1:0]       aLane;
      logic [DATA_W-1:0]       bLane;
      logic signed [DOT_W-1:0] aExt;
      logic signed [DOT_W-1:0] bExt;
      logic signed [DOT_W-1:0] sum;
      aLane = '0;
      bLane = '0;
      aExt  = '0;
      bExt  = '0;
      sum   = '0;
      for (int i = 0; i < LANES; i++) begin
         aLane = data_i[i*DATA_W +: DATA_W];
         bLane = wt_i[i*DATA_W +: DATA_W];
         aExt  = {{(DOT_W-DATA_W){modeSigned_i & aLane[DATA_W-1]}}, aLane};
         bExt  = {{(DOT_W-DATA_W){modeSigned_i & bLane[DATA_W-1]}}, bLane};
         sum   = sum + aExt * bExt;
      end
      dot_o = sum;
   end

endmodule

// File: rtl/mac_pe_simd.sv
// Systolic SIMD multiply-accumulate processing element: a shifting weight
// chain, 1-cycle activation forwarding and a 2-stage dot/accumulate pipeline
// with per-sample signedness, saturation and a sticky overflow flag.
module mac_pe_simd import mac_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int LANES  = LANES_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mode_signed,
   input  logic                    sat_en,
   input  logic                    wt_load,
   input  logic [LANES*DATA_W-1:0] wt_path_in,
   output logic [LANES*DATA_W-1:0] wt_path_out,
   input  logic                    valid_in,
   input  logic [LANES*DATA_W-1:0] data_in,
   input  logic [ACC_W-1:0]        acc_in,
   output logic [LANES*DATA_W-1:0] data_out,
   output logic                    data_valid_out,
   output logic [ACC_W-1:0]        acc_out,
   output logic                    acc_valid_out,
   input  logic                    ovf_clr,
   output logic                    ovf_sticky
);

   localparam int DOT_W = dotWidth(DATA_W, LANES);
   localparam int VEC_W = LANES * DATA_W;

   if (LANES < 1) begin : gLanesCheck
      $error("mac_pe_simd: LANES must be at least 1");
   end
   if (ACC_W < DOT_W) begin : gAccWidthCheck
      $error("mac_pe_simd: ACC_W too narrow for the exact lane dot sum");
   end
   if (ACC_W > MAX_W - 2) begin : gAccMaxCheck
      $error("mac_pe_simd: ACC_W exceeds the overflow helper width");
   end

   logic [VEC_W-1:0]        wt_q;
   logic [VEC_W-1:0]        dataOut_q;
   logic                    dataValid_q;
   logic signed [DOT_W-1:0] dot_q;
   logic [ACC_W-1:0]        accIn_q;
   logic                    modeSigned_q;
   logic                    satEn_q;
   logic                    s1Valid_q;
   logic [ACC_W-1:0]        accOut_q;
   logic                    accValid_q;
   logic                    ovf_q;

   logic signed [DOT_W-1:0] dotNow;
   logic signed [MAX_W-1:0] sumWide;
   logic [ACC_W-1:0]        accOut_d;
   logic                    ovfNow;

   mac_dot_lanes #(
      .DATA_W (DATA_W),
      .LANES  (LANES),
      .DOT_W  (DOT_W)
   ) uDot (
      .data_i       (data_in),
      .wt_i         (wt_q),
      .modeSigned_i (mode_signed),
      .dot_o        (dotNow)
   );

   // Exact stage-2 sum in the captured sample's mode, then range check and clamp or wrap.
   always_comb begin
      ovfNow   = 1'b0;
      sumWide  = {{(MAX_W-ACC_W){modeSigned_q & accIn_q[ACC_W-1]}}, accIn_q}
               + {{(MAX_W-DOT_W){dot_q[DOT_W-1]}}, dot_q};
      accOut_d = ACC_W'(accSatOvf(sumWide, ACC_W, modeSigned_q, satEn_q, ovfNow));
   end

   // Weight chain: shifts only on wt_load, so a same-cycle sample sees the old weights.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wt_q <= '0;
      end else if (wt_load) begin
         wt_q <= wt_path_in;
      end
   end

   // Forward activations to the next PE one cycle later, holding during bubbles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dataOut_q   <= '0;
         dataValid_q <= 1'b0;
      end else begin
         dataValid_q <= valid_in;
         if (valid_in) begin
            dataOut_q <= data_in;
         end
      end
   end

   // Stage 1 captures the dot sum together with the mode bits that travel with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1Valid_q    <= 1'b0;
         dot_q        <= '0;
         accIn_q      <= '0;
         modeSigned_q <= 1'b0;
         satEn_q      <= 1'b0;
      end else begin
         s1Valid_q <= valid_in;
         if (valid_in) begin
            dot_q        <= dotNow;
            accIn_q      <= acc_in;
            modeSigned_q <= mode_signed;
            satEn_q      <= sat_en;
         end
      end
   end

   // Stage 2 publishes the accumulated partial sum; acc_out holds across bubbles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         accOut_q   <= '0;
         accValid_q <= 1'b0;
      end else begin
         accValid_q <= s1Valid_q;
         if (s1Valid_q) begin
            accOut_q <= accOut_d;
         end
      end
   end

   // Sticky overflow: a new overflow outranks a clear arriving on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (s1Valid_q && ovfNow) begin
         ovf_q <= 1'b1;
      end else if (ovf_clr) begin
         ovf_q <= 1'b0;
      end
   end

   assign wt_path_out    = wt_q;
   assign data_out       = dataOut_q;
   assign data_valid_out = dataValid_q;
   assign acc_out        = accOut_q;
   assign acc_valid_out  = accValid_q;
   assign ovf_sticky     = ovf_q;

endmodule
